// File: rtl/ex_muldiv_if.sv
// Issue-side bundle between the EX stage and the HI/LO multiply/divide unit.
interface ex_muldiv_if;
  logic        Valid;
  logic [31:0] Ins;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] HiLoData;
  logic        HiLoSel;
  logic        Stall;
  logic        Busy;

  modport master (
    output Valid, Ins, Rdata1, Rdata2,
    input  HiLoData, HiLoSel, Stall, Busy
  );

  modport slave (
    input  Valid, Ins, Rdata1, Rdata2,
    output HiLoData, HiLoSel, Stall, Busy
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// Multiply is radix-2 shift-add, divide is restoring; both take 32 steps plus
// one sign-fix cycle, so Busy is high for 33 cycles per operation.
module ex_muldiv (
  input logic         CLK,
  input logic         RST,
  ex_muldiv_if.slave  bus
);

  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1a;
  localparam logic [5:0] FnDivu  = 6'h1b;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e      state;
  logic [5:0]  count;
  logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opb;       // multiplicand or divisor magnitude
  logic [31:0] orig;      // original dividend, returned as HI on divide by zero
  logic [31:0] hi;
  logic [31:0] lo;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;
  logic        is_div;

  logic        dec_en;
  logic [5:0]  funct;
  logic        is_mf;
  logic        is_hilo_op;
  logic        busy;
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_r;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        unused_ins;

  assign unused_ins = ^bus.Ins[25:6];

  // Decode and issue-side handshake outputs.
  always_comb begin
    dec_en     = bus.Valid && (bus.Ins[31:26] == 6'd0);
    funct      = bus.Ins[5:0];
    is_mf      = dec_en && ((funct == FnMfhi) || (funct == FnMflo));
    is_hilo_op = dec_en && ((funct inside {[FnMfhi:FnMtlo]}) || (funct inside {[FnMult:FnDivu]}));
    busy       = (state != StIdle);
    bus.Busy   = busy;
    bus.Stall  = RST && is_hilo_op && busy;
    // Gate with RST so reads go quiet the instant reset asserts.
    bus.HiLoSel  = RST && is_mf && !busy;
    bus.HiLoData = 32'd0;
    if (bus.HiLoSel) begin
      bus.HiLoData = (funct == FnMfhi) ? hi : lo;
    end
  end

  // Operand magnitudes and per-step datapath.
  always_comb begin
    op_signed = ~funct[0];
    a_neg     = op_signed & bus.Rdata1[31];
    b_neg     = op_signed & bus.Rdata2[31];
    mag_a     = a_neg ? (~bus.Rdata1 + 32'd1) : bus.Rdata1;
    mag_b     = b_neg ? (~bus.Rdata2 + 32'd1) : bus.Rdata2;

    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};

    // True difference is below 2^32 whenever div_ge holds, so 32 bits suffice.
    div_r    = acc[63:31];
    div_ge   = (div_r >= {1'b0, opb});
    div_diff = div_r[31:0] - opb;
    div_next = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

    prod_fix = neg_res ? (~acc + 64'd1) : acc;
    quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  // Control FSM, iteration registers and HI/LO.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= StIdle;
      count    <= 6'd0;
      acc      <= 64'd0;
      opb      <= 32'd0;
      orig     <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (dec_en) begin
            case (funct)
              FnMthi: hi <= bus.Rdata1;
              FnMtlo: lo <= bus.Rdata1;
              FnMult, FnMultu, FnDiv, FnDivu: begin
                acc      <= {32'd0, mag_a};
                opb      <= mag_b;
                orig     <= bus.Rdata1;
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (bus.Rdata2 == 32'd0);
                is_div   <= funct[1];
                count    <= 6'd0;
                state    <= funct[1] ? StDiv : StMul;
              end
              default: ;
            endcase
          end
        end
        StMul: begin
          acc   <= mul_next;
          count <= count + 6'd1;
          if (count == 6'd31) state <= StFix;
        end
        StDiv: begin
          acc   <= div_next;
          count <= count + 6'd1;
          if (count == 6'd31) state <= StFix;
        end
        StFix: begin
          if (!is_div) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else if (div_zero) begin
            hi <= orig;
            lo <= 32'hffff_ffff;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: expected HI/LO values are queued when an
// operation is issued and popped when MFHI/MFLO reads them back.
module tb_ex_muldiv;

  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1a;
  localparam logic [5:0] FnDivu  = 6'h1b;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference results from plain SV arithmetic.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo);
    logic signed [63:0] sp;
    logic [63:0] up;
    ehi = 32'd0;
    elo = 32'd0;
    case (f)
      FnMult: begin
        sp  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        ehi = sp[63:32];
        elo = sp[31:0];
      end
      FnMultu: begin
        up  = {32'd0, a} * {32'd0, b};
        ehi = up[63:32];
        elo = up[31:0];
      end
      FnDiv: begin
        if (b == 32'd0) begin
          elo = 32'hffff_ffff;
          ehi = a;
        end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
          elo = 32'h8000_0000;
          ehi = 32'd0;
        end else begin
          elo = $signed(a) / $signed(b);
          ehi = $signed(a) % $signed(b);
        end
      end
      FnDivu: begin
        if (b == 32'd0) begin
          elo = 32'hffff_ffff;
          ehi = a;
        end else begin
          elo = a / b;
          ehi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    bus.Valid  = v;
    bus.Ins    = {26'd0, f};
    bus.Rdata1 = a;
    bus.Rdata2 = b;
  endtask

  // Issue one mul/div, optionally hold an ADD during Busy, and measure Busy length.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit with_add);
    logic [31:0] ehi, elo;
    int n;
    bit add_ok;
    model(f, a, b, ehi, elo);
    exp_q.push_back(ehi);
    exp_q.push_back(elo);
    @(negedge clk);
    drive(1'b1, f, a, b);
    @(posedge clk);
    #1;
    if (with_add) drive(1'b1, FnAdd, a, b);
    else drive(1'b0, 6'd0, 32'd0, 32'd0);
    n = 0;
    add_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.Busy) break;
      n++;
      if (bus.Stall !== 1'b0) add_ok = 1'b0;
    end
    checks++;
    if (n != 33) $display("FAIL %s busy_cycles: got %0d expected 33", name, n);
    if (n != 33) errors++;
    if (with_add) begin
      checks++;
      if (!add_ok) begin
        $display("FAIL %s add_no_stall: ADD saw Stall=1 expected 0", name);
        errors++;
      end
    end
    drive(1'b0, 6'd0, 32'd0, 32'd0);
  endtask

  // Read HI or LO in IDLE and compare against the scoreboard head.
  task automatic read_hilo(input string name, input logic [5:0] f);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard: queue empty", name);
      errors++;
      exp = 32'hdead_beef;
    end else begin
      exp = exp_q.pop_front();
    end
    @(negedge clk);
    drive(1'b1, f, $urandom, $urandom);
    #1;
    checks++;
    if (bus.HiLoSel !== 1'b1 || bus.Stall !== 1'b0) begin
      $display("FAIL %s sel: HiLoSel=%b Stall=%b expected 1/0", name, bus.HiLoSel, bus.Stall);
      errors++;
    end
    checks++;
    if (bus.HiLoData !== exp) begin
      $display("FAIL %s data: got %h expected %h", name, bus.HiLoData, exp);
      errors++;
    end
    @(posedge clk);
    #1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset;
    drive(1'b1, FnMfhi, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.Busy, bus.Stall, bus.HiLoSel} !== 3'b000 || bus.HiLoData !== 32'd0) begin
      $display("FAIL reset_outputs: busy/stall/sel=%b data=%h expected 000/0",
               {bus.Busy, bus.Stall, bus.HiLoSel}, bus.HiLoData);
      errors++;
    end
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    read_hilo("reset_hi", FnMfhi);
    read_hilo("reset_lo", FnMflo);
  endtask

  task automatic test_mult_signed;
    run_op("mult", FnMult, 32'hffff_fffe, 32'h0000_0003, 1'b1);
    read_hilo("mult_hi", FnMfhi);
    read_hilo("mult_lo", FnMflo);
  endtask

  task automatic test_multu;
    run_op("multu", FnMultu, 32'hffff_ffff, 32'hffff_ffff, 1'b0);
    read_hilo("multu_hi", FnMfhi);
    read_hilo("multu_lo", FnMflo);
  endtask

  task automatic test_div_signed;
    run_op("div", FnDiv, 32'hffff_fff9, 32'd2, 1'b0);
    read_hilo("div_hi", FnMfhi);
    read_hilo("div_lo", FnMflo);
  endtask

  task automatic test_divu_zero;
    run_op("divu0", FnDivu, 32'd7, 32'd0, 1'b0);
    read_hilo("divu0_hi", FnMfhi);
    read_hilo("divu0_lo", FnMflo);
  endtask

  task automatic test_div_overflow;
    run_op("divovf", FnDiv, 32'h8000_0000, 32'hffff_ffff, 1'b0);
    read_hilo("divovf_hi", FnMfhi);
    read_hilo("divovf_lo", FnMflo);
  endtask

  task automatic test_stall_mflo;
    logic [31:0] ehi, elo, exp;
    int n;
    bit sel_bad;
    model(FnMult, 32'd5, 32'd6, ehi, elo);
    exp_q.push_back(elo);
    @(negedge clk);
    drive(1'b1, FnMult, 32'd5, 32'd6);
    @(posedge clk);
    #1;
    drive(1'b1, FnMflo, 32'd0, 32'd0);
    n = 0;
    sel_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.Stall) break;
      n++;
      if (bus.HiLoSel !== 1'b0) sel_bad = 1'b1;
    end
    checks++;
    if (n != 33) begin
      $display("FAIL stall_cycles: got %0d expected 33", n);
      errors++;
    end
    checks++;
    if (sel_bad) begin
      $display("FAIL stall_sel: HiLoSel=1 while stalled expected 0");
      errors++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (bus.HiLoSel !== 1'b1 || bus.HiLoData !== exp) begin
      $display("FAIL stall_mflo: sel=%b data=%h expected 1/%h", bus.HiLoSel, bus.HiLoData, exp);
      errors++;
    end
    @(posedge clk);
    #1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
  endtask

  task automatic test_mtlo_mflo;
    @(negedge clk);
    drive(1'b1, FnMtlo, 32'h0000_1234, 32'd0);
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin
      $display("FAIL mtlo_stall: got %b expected 0", bus.Stall);
      errors++;
    end
    exp_q.push_back(32'h0000_1234);
    @(posedge clk);
    #1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    read_hilo("mtlo_mflo", FnMflo);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(1'b1, FnDiv, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b1) begin
      $display("FAIL midrst_busy_before: got %b expected 1", bus.Busy);
      errors++;
    end
    rst = 1'b0;
    drive(1'b1, FnMflo, 32'd0, 32'd0);
    #1;
    checks++;
    if ({bus.Busy, bus.Stall, bus.HiLoSel} !== 3'b000 || bus.HiLoData !== 32'd0) begin
      $display("FAIL midrst_outputs: busy/stall/sel=%b data=%h expected 000/0",
               {bus.Busy, bus.Stall, bus.HiLoSel}, bus.HiLoData);
      errors++;
    end
    @(negedge clk);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    rst = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    read_hilo("midrst_hi", FnMfhi);
    read_hilo("midrst_lo", FnMflo);
    run_op("after_rst", FnMultu, 32'd3, 32'd4, 1'b0);
    read_hilo("after_rst_hi", FnMfhi);
    read_hilo("after_rst_lo", FnMflo);
  endtask

  initial begin
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    test_reset();
    test_mult_signed();
    test_multu();
    test_div_signed();
    test_divu_zero();
    test_div_overflow();
    test_stall_mflo();
    test_mtlo_mflo();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameters: none; the block SHALL be fixed at 32-bit operands and results.
REQ-002 CLK  input  1  — single clock; all state updates SHALL occur on its rising edge.
REQ-003 RST  input  1  — reset, asynchronous and active-low.
REQ-004 Valid  input  1  — Ins, Rdata1 and Rdata2 SHALL be qualified this cycle only when Valid=1.
REQ-005 Ins  input  32  — decoded instruction; opcode Ins[31:26], funct Ins[5:0].
REQ-006 Rdata1  input  32  — rs operand.
REQ-007 Rdata2  input  32  — rt operand.
REQ-008 HiLoData  output  32  — HI or LO value for MFHI/MFLO, else 0.
REQ-009 HiLoSel  output  1  — SHALL be 1 when HiLoData is to replace the ALU Result sent to the MA stage.
REQ-010 Stall  output  1  — SHALL be 1 when the upstream stage must hold Ins this cycle.
REQ-011 Busy  output  1  — SHALL be 1 while an iterative operation is in flight.

Function
REQ-012 Decode SHALL apply only when Valid=1 and Ins[31:26]=0.
REQ-013 Decoded funct values: MFHI=0x10, MTHI=0x11, MFLO=0x12, MTLO=0x13, MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B; all other values SHALL leave the block inert.
REQ-014 FSM states SHALL be IDLE, MUL, DIV, FIX; Busy SHALL equal (state != IDLE).
REQ-015 In IDLE, MULT/MULTU/DIV/DIVU at edge T SHALL latch operand magnitudes and result sign, clear the 6-bit count, and enter MUL or DIV.
REQ-016 MULT/DIV SHALL convert to magnitudes; MULTU/DIVU SHALL be unsigned.
REQ-017 MUL SHALL run a radix-2 shift-add: one bit per edge over edges T+1..T+32, then enter FIX.
REQ-018 DIV SHALL run restoring division: one quotient bit per edge over edges T+1..T+32, then enter FIX.
REQ-019 At edge T+33 FIX SHALL apply sign correction, write HI/LO and return to IDLE, giving Busy=1 for exactly 33 cycles.
REQ-020 Multiply results SHALL be HI = product[63:32] and LO = product[31:0], with the 64-bit two's-complement result for signed MULT.
REQ-021 Divide results SHALL be LO = quotient and HI = remainder; the signed quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero (Rdata2=0) SHALL give LO=0xFFFFFFFF and HI=Rdata1 (original value), with the same 33-cycle latency.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give LO=0x80000000 and HI=0.
REQ-024 MTHI/MTLO in IDLE SHALL write Rdata1 to HI/LO at that edge, with no stall.
REQ-025 MFHI/MFLO in IDLE SHALL drive HiLoSel=1 and HiLoData=HI/LO combinationally in the same cycle.
REQ-026 Stall SHALL be 1 combinationally whenever Busy=1 and the decoded funct is any HI/LO-touching op (0x10–0x13, 0x18–0x1B); in that case HiLoSel SHALL be 0 and no state SHALL change from Ins.
REQ-027 Stall SHALL be 1 during FIX; the stalled instruction SHALL issue in the first IDLE cycle and read or write the updated HI/LO.
REQ-028 Non-HI/LO instructions during Busy SHALL NOT stall.
REQ-029 Valid=0 SHALL force Stall=0 and HiLoSel=0.
REQ-030 A new multiply or divide SHALL NOT be accepted unless state=IDLE; there SHALL be no back-to-back overlap.

Reset
REQ-031 RST=0 SHALL asynchronously force state=IDLE, count=0, HI=0, LO=0 and all working registers to 0.
REQ-032 RST=0 SHALL immediately drive Busy=0, Stall=0, HiLoSel=0, HiLoData=0.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no HI/LO write.
REQ-034 After release, the first rising edge SHALL be able to accept a new operation.

Verification
REQ-035 Bench SHALL cover MULT with 0xFFFFFFFE × 0x00000003 → Busy for 33 cycles, then MFHI returns 0xFFFFFFFF and MFLO returns 0xFFFFFFFA.
REQ-036 Bench SHALL cover MULTU with 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 Bench SHALL cover DIV with −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with 7 / 0 → LO=0xFFFFFFFF, HI=0x00000007.
REQ-038 Bench SHALL cover DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
REQ-039 Bench SHALL cover MFLO issued 1 cycle after MULT 5 × 6 → Stall=1 for 33 cycles, then HiLoSel=1 with HiLoData=30; an ADD interleaved during Busy sees Stall=0.
REQ-040 Bench SHALL cover MTLO 0x1234 then MFLO in IDLE → HiLoData=0x1234 with no stall; RST pulsed at cycle 10 of a DIV → Busy=0 immediately and HI=LO=0.
